// File: rtl/slc3_mem_responder.sv
// Memory-side responder for the SLC-3 MAR/MDR bus: word RAM plus one memory-mapped
// I/O address, with programmable wait states and a one-cycle ready pulse.
//
// state   | meaning
// IDLE    | waiting for MEM_EN; request fields latched on acceptance
// BUSY    | counting wait states; access commits when the counter is zero
// DONE    | R (and ERR if out of range) high for this single cycle
// RELEASE | waiting for MEM_EN to drop so a held request cannot re-trigger
module slc3_mem_responder #(
  parameter int          ADDR_BITS   = 10,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MEM_EN,
  input  logic        MEM_WE,
  input  logic [15:0] MAR,
  input  logic [15:0] MDR,
  input  logic [15:0] SW,
  output logic [15:0] MDR_In,
  output logic        R,
  output logic        ERR,
  output logic [15:0] HEX_DATA
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, RELEASE} state_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt;
  logic [15:0]           addr_q;
  logic [15:0]           data_q;
  logic                  we_q;
  logic                  err_q;
  logic                  commit;
  logic                  is_io;
  logic                  in_range;
  logic                  ram_we;
  logic [ADDR_BITS-1:0]  ram_idx;
  logic [15:0]           ram [2**ADDR_BITS];

  assign is_io    = (addr_q == IO_ADDR);
  assign in_range = ((addr_q >> ADDR_BITS) == 16'd0) && !is_io;
  assign ram_idx  = addr_q[ADDR_BITS-1:0];
  // Reset on the commit edge wins, so the RAM write is gated by it too.
  assign ram_we   = commit && we_q && in_range && !Reset;

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    R         = 1'b0;
    ERR       = 1'b0;
    case (state)
      IDLE:    if (MEM_EN) state_nxt = BUSY;
      BUSY: begin
        if (cnt == 4'd0) begin
          commit    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        R         = 1'b1;
        ERR       = err_q;
        state_nxt = RELEASE;
      end
      RELEASE: if (!MEM_EN) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt      <= 4'd0;
      addr_q   <= 16'h0000;
      data_q   <= 16'h0000;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      MDR_In   <= 16'h0000;
      HEX_DATA <= 16'h0000;
    end else begin
      if (state == IDLE && MEM_EN) begin
        addr_q <= MAR;
        data_q <= MDR;
        we_q   <= MEM_WE;
        cnt    <= 4'(WAIT_CYCLES);
      end
      if (state == BUSY && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (commit) begin
        err_q <= !is_io && !in_range;
        if (!we_q) begin
          if (is_io)         MDR_In <= SW;
          else if (in_range) MDR_In <= ram[ram_idx];
          else               MDR_In <= 16'h0000;
        end else if (is_io) begin
          HEX_DATA <= data_q;
        end
      end
    end
  end

  // No reset on the array so it maps onto block RAM.
  always_ff @(posedge Clk) begin
    if (ram_we) ram[ram_idx] <= data_q;
  end

endmodule
